dmem_resp: RTL and testbench



---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_wbuf.sv | 73 +++++++
 rtl/dmem_resp.sv | 140 ++++++++++++++
 tb/tb_dmem_resp.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and its write buffer.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int          TIMEOUT_DEF  = 16;
  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  // Width of a timeout counter that must reach TIMEOUT_CYC-1; never narrower than one bit.
  function automatic int cnt_w(input int cyc);
    return (cyc <= 2) ? 1 : $clog2(cyc);
  endfunction

endpackage

// File: rtl/dmem_wbuf.sv
// One-entry posted write buffer: holds a store and drains it over the req/ack bus,
// dropping the entry with a one-cycle error pulse if the bus never acks.
module dmem_wbuf
  import dmem_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_push,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_ack,
  output logic        o_vld,
  output logic [31:0] o_addr,
  output logic [31:0] o_wdata,
  output logic        o_err
);

  localparam int            CW       = cnt_w(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  logic          vld_q, vld_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      vld_q   <= vld_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    vld_d   = vld_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (vld_q) begin
      if (i_ack) begin
        vld_d = 1'b0;
      end else if (cnt_q == CNT_LAST) begin
        vld_d = 1'b0;
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (i_push) begin
      vld_d   = 1'b1;
      addr_d  = i_addr;
      wdata_d = i_wdata;
      cnt_d   = '0;
    end
  end

  assign o_vld   = vld_q;
  assign o_addr  = addr_q;
  assign o_wdata = wdata_q;
  assign o_err   = err_q;

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: bridges the core's zero-wait data port onto a req/ack word bus,
// stalling the core until each access completes. Define DMEM_WBUF_EN for posted stores.
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int          TIMEOUT_CYC = TIMEOUT_DEF,
  parameter logic [31:0] ERR_DATA    = ERR_DATA_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_read_en,
  input  logic        i_write_en,
  input  logic [31:0] i_memaddr,
  input  logic [31:0] i_write_data,
  output logic [31:0] o_read_data,
  output logic        o_exstall,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_bus_err
);

  localparam int            CW       = cnt_w(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          we_q, we_d;
  logic          err_q, err_d;

  logic          req_any, accept;
  logic          wb_push, wb_vld, wb_err;
  logic [31:0]   wb_addr, wb_wdata;
  logic          unused_addr_lsb;

  assign req_any         = i_read_en | i_write_en;
  assign unused_addr_lsb = ^i_memaddr[1:0];

`ifdef DMEM_WBUF_EN
  // Stores post into the empty buffer; everything else waits for the drain, which keeps RAW order.
  assign wb_push = (state_q == IDLE) && i_write_en && !wb_vld;
  assign accept  = (state_q == IDLE) && i_read_en && !i_write_en && !wb_vld;

  dmem_wbuf #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wbuf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (wb_push),
    .i_addr  ({i_memaddr[31:2], 2'b00}),
    .i_wdata (i_write_data),
    .i_ack   (i_mem_ack),
    .o_vld   (wb_vld),
    .o_addr  (wb_addr),
    .o_wdata (wb_wdata),
    .o_err   (wb_err)
  );
`else
  assign wb_push  = 1'b0;
  assign wb_vld   = 1'b0;
  assign wb_err   = 1'b0;
  assign wb_addr  = '0;
  assign wb_wdata = '0;
  assign accept   = (state_q == IDLE) && req_any;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = BUSY;
          addr_d  = {i_memaddr[31:2], 2'b00};
          wdata_d = i_write_data;
          we_d    = i_write_en;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        // An ack on the final count still wins over the timeout.
        if (i_mem_ack) begin
          if (!we_q) rdata_d = i_mem_rdata;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          if (!we_q) rdata_d = ERR_DATA;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_mem_req   = (state_q == BUSY) | wb_vld;
  assign o_mem_we    = ((state_q == BUSY) & we_q) | wb_vld;
  assign o_mem_addr  = wb_vld ? wb_addr : addr_q;
  assign o_mem_wdata = wb_vld ? wb_wdata : wdata_q;
  assign o_read_data = rdata_q;
  assign o_bus_err   = err_q | wb_err;
  // Gated by rst so the core is released the moment reset lands, even with its request still up.
  assign o_exstall   = !rst & ((state_q == BUSY) | ((state_q == IDLE) & req_any & !wb_push));

endmodule

// File: tb/tb_dmem_resp.sv
// Randomized bench for dmem_resp: a reactive bus responder plus a transaction-level model
// of stall length, read data, bus beat and error pulses.
module tb_dmem_resp;

  localparam int          TO  = 16;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
`ifdef DMEM_WBUF_EN
  localparam bit WBUF = 1'b1;
`else
  localparam bit WBUF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_read_en, i_write_en;
  logic [31:0] i_memaddr, i_write_data;
  logic [31:0] o_read_data;
  logic        o_exstall, o_mem_req, o_mem_we, o_bus_err;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;

  logic        ack_r = 1'b0, ack_inj = 1'b0;
  int          bus_dly = 0;
  logic [31:0] bus_rdata = '0;
  int          bcnt = 0, cap_n = 0, err_n = 0;
  logic [31:0] cap_addr = '0, cap_wdata = '0;
  logic        cap_we = 1'b0;
  logic [31:0] rd_model = '0;
  int          n_chk = 0, n_fail = 0;

  assign i_mem_ack = ack_r | ack_inj;

  always #5 clk = ~clk;

  dmem_resp #(.TIMEOUT_CYC(TO), .ERR_DATA(ERR)) dut (
    .clk(clk), .rst(rst),
    .i_read_en(i_read_en), .i_write_en(i_write_en),
    .i_memaddr(i_memaddr), .i_write_data(i_write_data),
    .o_read_data(o_read_data), .o_exstall(o_exstall),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .o_bus_err(o_bus_err)
  );

  // Bus slave: acks bus_dly cycles after req rises (never if bus_dly >= TO); records the first beat.
  initial begin
    i_mem_rdata = '0;
    forever begin
      @(negedge clk);
      ack_r = 1'b0;
      if (o_mem_req) begin
        if (bcnt == 0) begin
          cap_addr  = o_mem_addr;
          cap_we    = o_mem_we;
          cap_wdata = o_mem_wdata;
          cap_n++;
        end
        if (bcnt == bus_dly) begin
          ack_r       = 1'b1;
          i_mem_rdata = bus_rdata;
        end else begin
          i_mem_rdata = $urandom;
        end
        bcnt++;
      end else begin
        bcnt = 0;
      end
    end
  end

  always @(negedge clk) if (o_bus_err) err_n++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One core access end to end, checked against the transaction-level expectation.
  task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input int dly, input logic [31:0] bd);
    int stall, n, e0, c0, exp_stall;
    bit posted, tmo;
    posted    = WBUF && wr;
    tmo       = (dly >= TO);
    exp_stall = posted ? 0 : (tmo ? TO + 1 : dly + 2);
    bus_dly   = dly;
    bus_rdata = bd;
    e0        = err_n;
    c0        = cap_n;
    if (rd && !wr) rd_model = tmo ? ERR : bd;
    @(posedge clk); #1;
    i_read_en = rd; i_write_en = wr; i_memaddr = a; i_write_data = d;
    stall = 0;
    while (stall < 200) begin
      @(negedge clk);
      if (!o_exstall) break;
      stall++;
    end
    chk("stall_cycles", stall, exp_stall);
    chk("read_data", o_read_data, rd_model);
    @(posedge clk); #1;
    i_read_en = 1'b0; i_write_en = 1'b0;
    n = 0;
    while (o_mem_req && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("req_dropped", 32'(o_mem_req), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("bus_err_pulses", err_n - e0, 32'(tmo));
    chk("bus_beats", cap_n - c0, 32'd1);
    chk("bus_addr", cap_addr, {a[31:2], 2'b00});
    chk("bus_we", 32'(cap_we), 32'(wr));
    if (wr) chk("bus_wdata", cap_wdata, d);
    chk("read_data_hold", o_read_data, rd_model);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rd, wr;
    int k, dly, stall, e0;
    rst = 1'b1;
    i_read_en = 1'b0; i_write_en = 1'b0; i_memaddr = '0; i_write_data = '0;
    #3;
    chk("rst_exstall", 32'(o_exstall), 32'd0);
    chk("rst_req", 32'(o_mem_req), 32'd0);
    chk("rst_we", 32'(o_mem_we), 32'd0);
    chk("rst_addr", o_mem_addr, 32'd0);
    chk("rst_wdata", o_mem_wdata, 32'd0);
    chk("rst_rdata", o_read_data, 32'd0);
    chk("rst_err", 32'(o_bus_err), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    access(1'b1, 1'b0, 32'h0000_0104, 32'h0, 3, 32'h1234_5678);
    access(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_0001, 0, 32'h5555_5555);
    access(1'b1, 1'b0, 32'h0000_0200, 32'h0, TO + 8, 32'h7777_7777);
    access(1'b1, 1'b1, 32'h0000_0043, 32'hA5A5_0043, 1, 32'h9999_9999);
    access(1'b1, 1'b0, 32'h0000_0300, 32'h0, TO - 1, 32'h0BAD_F00D);

    // Reset in the middle of a load: bus released at once, a late ack is ignored.
    bus_dly = 1000;
    e0 = err_n;
    @(posedge clk); #1;
    i_read_en = 1'b1; i_memaddr = 32'h88;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    rd_model = '0;
    #1;
    chk("rst_mid_req", 32'(o_mem_req), 32'd0);
    chk("rst_mid_exstall", 32'(o_exstall), 32'd0);
    i_read_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; ack_inj = 1'b1;
    @(posedge clk); #1;
    ack_inj = 1'b0;
    @(negedge clk);
    chk("late_ack_rdata", o_read_data, rd_model);
    chk("late_ack_req", 32'(o_mem_req), 32'd0);
    chk("late_ack_exstall", 32'(o_exstall), 32'd0);
    chk("late_ack_err", err_n - e0, 32'd0);

`ifdef DMEM_WBUF_EN
    // Posted store followed at once by a load: the load waits out the drain, then reads normally.
    dly = 2;
    bus_dly = dly; bus_rdata = 32'h4444_1111;
    @(posedge clk); #1;
    i_write_en = 1'b1; i_memaddr = 32'h60; i_write_data = 32'h1357_2468;
    @(negedge clk);
    chk("wbuf_store_stall", 32'(o_exstall), 32'd0);
    @(posedge clk); #1;
    i_write_en = 1'b0; i_read_en = 1'b1;
    stall = 0;
    while (stall < 200) begin
      @(negedge clk);
      if (!o_exstall) break;
      stall++;
    end
    rd_model = 32'h4444_1111;
    chk("wbuf_load_stall", stall, 32'((dly + 1) + (dly + 2)));
    chk("wbuf_load_data", o_read_data, rd_model);
    @(posedge clk); #1 i_read_en = 1'b0;
    repeat (2) @(posedge clk);
`endif

    for (int i = 0; i < 48; i++) begin
      k  = $urandom_range(0, 7);
      rd = (k <= 3) || (k == 6) || (k == 7);
      wr = (k == 4) || (k == 5) || (k == 6);
      dly = ($urandom_range(0, 7) == 0) ? TO + $urandom_range(0, 4) : $urandom_range(0, 5);
      access(rd, wr, $urandom, $urandom, dly, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
